// File: rtl/bus_arbiter8_pkg.sv
// Shared arbiter definitions: requester count, index/counter widths and
// the two-state ownership encoding reused by arbiters built on this slice.
package bus_arbiter8_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 5;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   typedef logic [N_REQ-1:0] req_t;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [CNT_W-1:0] cnt_t;

   function automatic req_t onehot(input idx_t i);
      return req_t'(1) << i;
   endfunction

endpackage

// File: rtl/bus_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface bus_arbiter8_if;
   import bus_arbiter8_pkg::*;

   req_t req;
   req_t gnt;
   idx_t sel;
   logic busy;
   idx_t ptr;

   modport master (output req, input gnt, sel, busy, ptr);
   modport slave  (input req, output gnt, sel, busy, ptr);

endinterface

// File: rtl/bus_arbiter8_rr_pick8.sv
// Rotating first-set-bit search: scans req_i upward from ptr_i, wrapping 7->0.
module rr_pick8
   import bus_arbiter8_pkg::*;
(
   input  req_t req_i,
   input  idx_t ptr_i,
   output logic found_o,
   output idx_t idx_o
);

   logic [2*N_REQ-1:0] req2;
   req_t               rot;

   always_comb begin
      req2    = {req_i, req_i};
      rot     = req_t'(req2 >> ptr_i);
      found_o = |rot;
      idx_o   = ptr_i;
      // Walk from the far end so the nearest set bit to ptr_i is written last.
      for (int unsigned i = N_REQ; i > 0; i--) begin
         if (rot[i-1]) idx_o = ptr_i + idx_t'(i - 1);
      end
   end

endmodule

// File: rtl/bus_arbiter8.sv
// Eight-way round-robin bus arbiter with a per-owner hold limit and
// registered one-hot grant / binary select outputs.
module bus_arbiter8
   import bus_arbiter8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
)(
   input  logic          clk_i,
   input  logic          rst_i,
   bus_arbiter8_if.slave bus
);

   logic [0:0] state_q, state_d;
   req_t       gnt_q, gnt_d;
   idx_t       sel_q, sel_d;
   idx_t       ptr_q, ptr_d;
   cnt_t       cnt_q, cnt_d;

   logic owned;
   logic rel_now;
   idx_t arb_ptr;
   logic found;
   idx_t win;

   assign owned   = (state_q == ST_OWNED);
   assign rel_now = owned && (!bus.req[sel_q] || (cnt_q == cnt_t'(MAX_HOLD)));
   // A releasing owner moves the pointer past itself before this cycle's search.
   assign arb_ptr = rel_now ? sel_q + idx_t'(1) : ptr_q;

   rr_pick8 u_pick (
      .req_i   (bus.req),
      .ptr_i   (arb_ptr),
      .found_o (found),
      .idx_o   (win)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = arb_ptr;
      cnt_d   = cnt_q;
      if (owned && !rel_now) begin
         cnt_d = cnt_q + cnt_t'(1);
      end else if (found) begin
         state_d = ST_OWNED;
         gnt_d   = onehot(win);
         sel_d   = win;
         cnt_d   = cnt_t'(1);
      end else begin
         state_d = ST_IDLE;
         gnt_d   = '0;
         sel_d   = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.busy = |gnt_q;
   assign bus.ptr  = ptr_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Scoreboard bench for bus_arbiter8: two instances (MAX_HOLD 4 and 1) share one
// request stream and are compared against a queue-fed behavioural model.
module tb_bus_arbiter8;

   localparam int MH0 = 4;
   localparam int MH1 = 1;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
      logic [2:0] ptr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t q0[$];
   exp_t q1[$];

   int m_owner[2];
   int m_hold[2];
   int m_ptr[2];
   int waitc[2][8];

   bus_arbiter8_if bus0 ();
   bus_arbiter8_if bus1 ();

   assign bus0.req = req;
   assign bus1.req = req;

   bus_arbiter8 #(.MAX_HOLD(MH0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
   bus_arbiter8 #(.MAX_HOLD(MH1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

   always #5 clk = ~clk;

   function automatic int mhold(input int k);
      return (k == 0) ? MH0 : MH1;
   endfunction

   function automatic exp_t act_of(input int k);
      exp_t a;
      if (k == 0) a = '{gnt: bus0.gnt, sel: bus0.sel, busy: bus0.busy, ptr: bus0.ptr};
      else        a = '{gnt: bus1.gnt, sel: bus1.sel, busy: bus1.busy, ptr: bus1.ptr};
      return a;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1;
         m_hold[k]  = 0;
         m_ptr[k]   = 0;
         for (int i = 0; i < 8; i++) waitc[k][i] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   // One clock of the arbitration rules, then queue the outputs expected after it.
   task automatic model_step(input int k, input logic [7:0] r);
      bit   rel;
      int   w;
      exp_t e;
      rel = 0;
      if (m_owner[k] >= 0) begin
         if (!r[m_owner[k]] || m_hold[k] == mhold(k)) begin
            rel      = 1;
            m_ptr[k] = (m_owner[k] + 1) % 8;
         end else begin
            m_hold[k]++;
         end
      end
      if (m_owner[k] < 0 || rel) begin
         w = -1;
         for (int d = 0; d < 8; d++)
            if (w < 0 && r[(m_ptr[k] + d) % 8]) w = (m_ptr[k] + d) % 8;
         m_owner[k] = w;
         m_hold[k]  = (w >= 0) ? 1 : 0;
      end
      e.gnt  = (m_owner[k] >= 0) ? (8'd1 << m_owner[k]) : 8'd0;
      e.sel  = (m_owner[k] >= 0) ? 3'(m_owner[k]) : 3'd0;
      e.busy = (m_owner[k] >= 0);
      e.ptr  = 3'(m_ptr[k]);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic push(input logic [7:0] r);
      model_step(0, r);
      model_step(1, r);
   endtask

   task automatic cyc(input logic [7:0] r);
      @(negedge clk);
      req = r;
      push(r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push(req);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon_inst(input int k, input logic [7:0] r);
      exp_t a;
      exp_t e;
      int   worst;
      a = act_of(k);
      n_tests++;
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
         n_fail++;
         $display("FAIL sb%0d: output with no expectation queued at %0t", k, $time);
      end else begin
         e = (k == 0) ? q0.pop_front() : q1.pop_front();
         if (a !== e) begin
            n_fail++;
            $display("FAIL sb%0d: got gnt=%h sel=%0d busy=%b ptr=%0d expected gnt=%h sel=%0d busy=%b ptr=%0d at %0t",
                     k, a.gnt, a.sel, a.busy, a.ptr, e.gnt, e.sel, e.busy, e.ptr, $time);
         end
      end
      n_tests++;
      if ($countones(a.gnt) > 1 || a.busy !== (a.gnt != 0) || (a.busy && !a.gnt[a.sel])) begin
         n_fail++;
         $display("FAIL onehot%0d: got gnt=%h sel=%0d busy=%b required one-hot gnt matching sel at %0t",
                  k, a.gnt, a.sel, a.busy, $time);
      end
      worst = 0;
      for (int i = 0; i < 8; i++) begin
         if (r[i] && !a.gnt[i]) waitc[k][i]++;
         else                   waitc[k][i] = 0;
         if (waitc[k][i] > worst) worst = waitc[k][i];
      end
      n_tests++;
      if (worst > 7 * mhold(k) + 1) begin
         n_fail++;
         $display("FAIL wait%0d: got %0d cycles waiting required <= %0d at %0t",
                  k, worst, 7 * mhold(k) + 1, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            for (int k = 0; k < 2; k++) chk($sformatf("rst_out%0d", k), 32'(act_of(k)), 32'd0);
         end else begin
            mon_inst(0, req);
            mon_inst(1, req);
         end
      end
   end

   initial begin
      logic [7:0] r;
      logic [7:0] mask;
      model_reset();

      // Idle after reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(8'h00);
         @(posedge clk); #2;
         chk("idle_gnt", 32'(bus0.gnt), 32'h0);
         chk("idle_ptr", 32'(bus0.ptr), 32'h0);
      end

      // Basic grant, early release on dropped request
      cyc(8'h24);
      @(posedge clk); #2;
      chk("first_gnt", 32'(bus0.gnt), 32'h04);
      chk("first_sel", 32'(bus0.sel), 32'd2);
      cyc(8'h24);
      cyc(8'h20);
      @(posedge clk); #2;
      chk("handover_gnt", 32'(bus0.gnt), 32'h20);
      chk("handover_sel", 32'(bus0.sel), 32'd5);
      chk("handover_ptr", 32'(bus0.ptr), 32'd3);

      // All requesting: full rotation with hold limit, and per-cycle rotation at MAX_HOLD=1
      do_reset();
      for (int k = 0; k < 36; k++) begin
         cyc(8'hFF);
         @(posedge clk); #2;
         chk("rot_sel", 32'(bus0.sel), 32'((k / MH0) % 8));
         chk("rot_ptr", 32'(bus0.ptr), 32'((k / MH0) % 8));
         chk("rot_busy", 32'(bus0.busy), 32'd1);
         chk("rot1_sel", 32'(bus1.sel), 32'(k % 8));
         chk("rot1_ptr", 32'(bus1.ptr), 32'(k % 8));
      end

      // Owner 7 hold-out with requester 0 waiting: pointer wraps to 0
      do_reset();
      cyc(8'h80);
      repeat (3) cyc(8'h81);
      @(posedge clk); #2;
      chk("wrap_pre_gnt", 32'(bus0.gnt), 32'h80);
      cyc(8'h81);
      @(posedge clk); #2;
      chk("wrap_gnt", 32'(bus0.gnt), 32'h01);
      chk("wrap_ptr", 32'(bus0.ptr), 32'd0);

      // Asynchronous reset pulse between edges while requester 6 owns the bus
      do_reset();
      repeat (6) cyc(8'h40);
      @(posedge clk); #2;
      chk("pulse_pre_sel", 32'(bus0.sel), 32'd6);
      cyc(8'h40);
      #2 rst = 1'b1;
      #1;
      chk("pulse_gnt", 32'(bus0.gnt), 32'h0);
      chk("pulse_busy", 32'(bus0.busy), 32'd0);
      chk("pulse_sel", 32'(bus0.sel), 32'd0);
      chk("pulse_ptr", 32'(bus0.ptr), 32'd0);
      #1 rst = 1'b0;
      model_reset();
      push(req);
      @(posedge clk); #2;
      chk("post_pulse_gnt", 32'(bus0.gnt), 32'h40);
      chk("post_pulse_ptr", 32'(bus0.ptr), 32'd0);

      // Random traffic
      do_reset();
      r = '0;
      for (int n = 0; n < 10000; n++) begin
         mask = '0;
         for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) mask[b] = 1'b1;
         r = r ^ mask;
         if ($urandom_range(15) == 0) r = 8'($urandom);
         if (m_owner[0] >= 0 && $urandom_range(5) == 0) r[m_owner[0]] = 1'b0;
         if (n == 5000) begin
            do_reset();
            r = '0;
         end
         cyc(r);
      end

      repeat (3) cyc(8'h00);
      @(posedge clk); #3;
      chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
